// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, NOP word, reset PC.
// IF_MISALIGN_TRAP_EN adds the TRAP state.
package if_fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2
`ifdef IF_MISALIGN_TRAP_EN
      ,IF_TRAP = 2'd3
`endif
   } if_state_t;

   function automatic logic [31:0] align4(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_pc_sel.sv
// Next-PC select for the fetch stage: first fetch, sequential or redirect, word aligned.
// IF_MISALIGN_TRAP_EN adds the misaligned-redirect detect output.
module if_pc_sel
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic        first_i,
   input  logic [31:0] pc_i,
   input  logic        pcsrc_i,
   input  logic [31:0] target_i,
   output logic [31:0] next_pc_o
`ifdef IF_MISALIGN_TRAP_EN
   ,output logic       misalign_o
`endif
);

   always_comb begin
      next_pc_o = pc_i + 32'd4;
      if (first_i)      next_pc_o = align4(RESET_PC);
      else if (pcsrc_i) next_pc_o = align4(target_i);
   end

`ifdef IF_MISALIGN_TRAP_EN
   // The first fetch ignores the redirect, so it can never trap.
   assign misalign_o = !first_i && pcsrc_i && (target_i[1:0] != 2'b00);
`endif

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, memory-latency wait, instruction latch, done pulse.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirects (adds o_misaligned).
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = PC_RESET_DEFAULT,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        en_IF,
   input  logic        i_PCSrc,
   input  logic [31:0] i_branchTarget,
   input  logic [31:0] i_mem_instr,
   output logic [31:0] o_instrAddr,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pcPlus4,
   output logic        o_valid,
   output logic        o_done
`ifdef IF_MISALIGN_TRAP_EN
   ,output logic       o_misaligned
`endif
);

   localparam logic [31:0] RESET_PC_A = align4(RESET_PC);
   localparam logic [2:0]  LAT        = 3'(MEM_LATENCY);

   if_state_t   state_q, state_d;
   logic [2:0]  cnt_q;
   logic [31:0] addr_q, instr_q, pc_q, next_pc;
   logic        valid_q, done_q, accept, expire, trap;

   if_pc_sel #(.RESET_PC(RESET_PC)) u_pc_sel (
      .first_i   (state_q == IF_IDLE),
      .pc_i      (pc_q),
      .pcsrc_i   (i_PCSrc),
      .target_i  (i_branchTarget),
      .next_pc_o (next_pc)
`ifdef IF_MISALIGN_TRAP_EN
      ,.misalign_o(trap)
`endif
   );

`ifndef IF_MISALIGN_TRAP_EN
   assign trap = 1'b0;
`endif

   assign accept = en_IF && (state_q == IF_IDLE || state_q == IF_HOLD);
   assign expire = (state_q == IF_FETCH) && (cnt_q == 3'd0);

   always_comb begin
      state_d = state_q;
      if (accept) begin
`ifdef IF_MISALIGN_TRAP_EN
         if (trap) state_d = IF_TRAP;
         else
`endif
         state_d = IF_FETCH;
      end else if (expire) begin
         state_d = IF_HOLD;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= IF_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= RESET_PC_A;
         instr_q <= NOP_INSTR;
         pc_q    <= RESET_PC_A;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= expire;
         // Counter runs down to zero; the capture happens on the edge after it hits zero.
         if (accept && !trap) begin
            addr_q <= next_pc;
            cnt_q  <= LAT;
         end else if (state_q == IF_FETCH && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (expire) begin
            instr_q <= i_mem_instr;
            pc_q    <= addr_q;
            valid_q <= 1'b1;
         end
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   logic mis_q;
   always_ff @(posedge i_clk) begin
      if (!i_reset_n)         mis_q <= 1'b0;
      else if (accept && trap) mis_q <= 1'b1;
   end
   assign o_misaligned = mis_q;
`endif

   assign o_instrAddr = addr_q;
   assign o_instr     = instr_q;
   assign o_pc        = pc_q;
   assign o_pcPlus4   = pc_q + 32'd4;
   assign o_valid     = valid_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: three instances (default, wrapping reset PC, latency 3).
// Stimulus pushes expected completions; a negedge monitor pops and compares on o_done.
module tb_if_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rstn [3];
   logic        en   [3];
   logic        pcsrc[3];
   logic [31:0] tgt  [3];
   logic [31:0] memi [3];
   logic [31:0] addr [3];
   logic [31:0] instr[3];
   logic [31:0] pc   [3];
   logic [31:0] pc4  [3];
   logic        valid[3];
   logic        done [3];
`ifdef IF_MISALIGN_TRAP_EN
   logic        mis  [3];
`endif

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0010_0093 : {a[15:0], 16'h0013};
   endfunction

   assign memi[0] = memf(addr[0]);
   assign memi[1] = memf(addr[1]);
   assign memi[2] = memf(addr[2]);

   if_fetch dut0 (
      .i_clk(clk), .i_reset_n(rstn[0]), .en_IF(en[0]), .i_PCSrc(pcsrc[0]),
      .i_branchTarget(tgt[0]), .i_mem_instr(memi[0]), .o_instrAddr(addr[0]),
      .o_instr(instr[0]), .o_pc(pc[0]), .o_pcPlus4(pc4[0]), .o_valid(valid[0]),
      .o_done(done[0])
`ifdef IF_MISALIGN_TRAP_EN
      ,.o_misaligned(mis[0])
`endif
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .i_clk(clk), .i_reset_n(rstn[1]), .en_IF(en[1]), .i_PCSrc(pcsrc[1]),
      .i_branchTarget(tgt[1]), .i_mem_instr(memi[1]), .o_instrAddr(addr[1]),
      .o_instr(instr[1]), .o_pc(pc[1]), .o_pcPlus4(pc4[1]), .o_valid(valid[1]),
      .o_done(done[1])
`ifdef IF_MISALIGN_TRAP_EN
      ,.o_misaligned(mis[1])
`endif
   );

   if_fetch #(.MEM_LATENCY(3)) dut2 (
      .i_clk(clk), .i_reset_n(rstn[2]), .en_IF(en[2]), .i_PCSrc(pcsrc[2]),
      .i_branchTarget(tgt[2]), .i_mem_instr(memi[2]), .o_instrAddr(addr[2]),
      .o_instr(instr[2]), .o_pc(pc[2]), .o_pcPlus4(pc4[2]), .o_valid(valid[2]),
      .o_done(done[2])
`ifdef IF_MISALIGN_TRAP_EN
      ,.o_misaligned(mis[2])
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push(input int k, input exp_t e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: every o_done must match the oldest outstanding expectation for that instance.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k] === 1'b1) begin
            exp_t e;
            logic have;
            have = 1'b1;
            case (k)
               0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
               1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
               default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
            endcase
            chk($sformatf("dut%0d_done_expected", k), 32'(have), 32'd1);
            if (have) begin
               chk($sformatf("dut%0d_instr", k), instr[k], e.instr);
               chk($sformatf("dut%0d_pc", k), pc[k], e.pc);
               chk($sformatf("dut%0d_pcPlus4", k), pc4[k], e.pc + 32'd4);
               chk($sformatf("dut%0d_valid", k), 32'(valid[k]), 32'd1);
               chk($sformatf("dut%0d_done_cycle", k), 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // One fetch: accept on the next edge, check the issued address, then wait for completion.
   task automatic fetch(input int k, input logic ps, input logic [31:0] t,
                        input logic [31:0] exp_addr, input logic [31:0] exp_instr,
                        input int lat, input bit hold_en);
      exp_t e;
      logic [31:0] old_instr;
      logic old_valid;
      bit seen;
      @(negedge clk);
      old_instr = instr[k];
      old_valid = valid[k];
      en[k] = 1'b1; pcsrc[k] = ps; tgt[k] = t;
      e.instr = exp_instr; e.pc = exp_addr; e.cyc = cyc + lat + 2;
      push(k, e);
      @(posedge clk); #1;
      if (!hold_en) en[k] = 1'b0;
      pcsrc[k] = 1'b0; tgt[k] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk($sformatf("dut%0d_addr_after_accept", k), addr[k], exp_addr);
      chk($sformatf("dut%0d_instr_held_in_fetch", k), instr[k], old_instr);
      chk($sformatf("dut%0d_valid_held_in_fetch", k), 32'(valid[k]), 32'(old_valid));
      chk($sformatf("dut%0d_no_early_done", k), 32'(done[k]), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done[k] === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      en[k] = 1'b0;
      chk($sformatf("dut%0d_done_seen", k), 32'(seen), 32'd1);
      chk($sformatf("dut%0d_addr_stable", k), addr[k], exp_addr);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rstn[k] = 1'b0; en[k] = 1'b0; pcsrc[k] = 1'b0; tgt[k] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr0", addr[0], 32'h0);
      chk("rst_instr0", instr[0], 32'h0000_0013);
      chk("rst_pc0", pc[0], 32'h0);
      chk("rst_pc4_0", pc4[0], 32'h4);
      chk("rst_valid0", 32'(valid[0]), 32'd0);
      chk("rst_done0", 32'(done[0]), 32'd0);
      chk("rst_addr1", addr[1], 32'hFFFF_FFFC);
      chk("rst_pc4_1", pc4[1], 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
      chk("rst_mis0", 32'(mis[0]), 32'd0);
`endif
      for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

      // Reset fetch, sequential flow, redirect with PCSrc dropped during FETCH.
      fetch(0, 1'b0, 32'h0,  32'h0000_0000, 32'h0010_0093, 1, 1'b0);
      fetch(0, 1'b0, 32'h0,  32'h0000_0004, 32'h0004_0013, 1, 1'b0);
      fetch(0, 1'b0, 32'h0,  32'h0000_0008, 32'h0008_0013, 1, 1'b0);
      fetch(0, 1'b0, 32'h0,  32'h0000_000C, 32'h000C_0013, 1, 1'b0);
      fetch(0, 1'b1, 32'h40, 32'h0000_0040, 32'h0040_0013, 1, 1'b0);
      fetch(0, 1'b0, 32'h0,  32'h0000_0044, 32'h0044_0013, 1, 1'b0);

`ifndef IF_MISALIGN_TRAP_EN
      fetch(0, 1'b1, 32'h42, 32'h0000_0040, 32'h0040_0013, 1, 1'b0);
`else
      @(negedge clk);
      en[0] = 1'b1; pcsrc[0] = 1'b1; tgt[0] = 32'h42;
      @(posedge clk); #1;
      en[0] = 1'b0; pcsrc[0] = 1'b0;
      @(negedge clk);
      chk("trap_mis", 32'(mis[0]), 32'd1);
      chk("trap_addr", addr[0], 32'h44);
      chk("trap_pc", pc[0], 32'h44);
      en[0] = 1'b1;
      repeat (6) @(negedge clk);
      en[0] = 1'b0;
      chk("trap_addr_hold", addr[0], 32'h44);
      chk("trap_pc_hold", pc[0], 32'h44);
      chk("trap_instr_hold", instr[0], 32'h0044_0013);
      chk("trap_mis_sticky", 32'(mis[0]), 32'd1);
      rstn[0] = 1'b0;
      @(posedge clk); #1;
      rstn[0] = 1'b1;
      @(negedge clk);
      chk("trap_mis_cleared", 32'(mis[0]), 32'd0);
`endif

      // PC wrap past the top of the address space.
      fetch(1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFC_0013, 1, 1'b0);
      fetch(1, 1'b0, 32'h0, 32'h0000_0000, 32'h0010_0093, 1, 1'b0);

      // Latency 3 with en_IF held through FETCH: one completion only.
      fetch(2, 1'b0, 32'h0, 32'h0000_0000, 32'h0010_0093, 3, 1'b1);
      repeat (6) @(negedge clk);
      chk("lat3_no_refetch_addr", addr[2], 32'h0);

      // Reset in FETCH discards the fetch; next fetch restarts at RESET_PC.
      @(negedge clk);
      en[2] = 1'b1;
      @(posedge clk); #1;
      en[2] = 1'b0;
      @(negedge clk);
      chk("midrst_addr_issued", addr[2], 32'h4);
      rstn[2] = 1'b0;
      @(posedge clk); #1;
      rstn[2] = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_valid", 32'(valid[2]), 32'd0);
      chk("midrst_instr", instr[2], 32'h0000_0013);
      chk("midrst_addr", addr[2], 32'h0);
      fetch(2, 1'b0, 32'h0, 32'h0000_0000, 32'h0010_0093, 3, 1'b0);

      repeat (4) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
